// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode map, control bundle and forward-select encodings for the
// pipelined control unit of the 16-bit, 4-bit-opcode CPU.
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_RED    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int unsigned CTRL_ALUOP_W = 3;

  typedef struct packed {
    logic [CTRL_ALUOP_W-1:0] alu_op;
    logic                    alu_src;
    logic                    branch;
    logic                    branch_src;
    logic                    pcs;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    reg_write;
    logic                    halt;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Combinational opcode decoder: control bundle plus source-operand usage flags.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] i_opcode,
  output ctrl_t      o_ctrl,
  output logic       o_rs_used,
  output logic       o_rt_used
);

  always_comb begin
    o_ctrl    = CTRL_NOP;
    o_rs_used = 1'b0;
    o_rt_used = 1'b0;

    if (!i_opcode[3]) begin
      o_ctrl.alu_op    = i_opcode[2:0];
      o_ctrl.reg_write = 1'b1;
      o_ctrl.alu_src   = (i_opcode == OP_SLL) || (i_opcode == OP_SRA) ||
                         (i_opcode == OP_ROR);
    end

    case (i_opcode)
      OP_LW: begin
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      OP_LLB, OP_LHB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      OP_B, OP_BR: begin
        o_ctrl.branch     = 1'b1;
        o_ctrl.branch_src = i_opcode[0];
      end
      OP_PCS: begin
        o_ctrl.pcs       = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_HLT: o_ctrl.halt = 1'b1;
      default: ;
    endcase

    o_rs_used = (i_opcode <= OP_LHB) || (i_opcode == OP_BR);
    o_rt_used = (i_opcode <= OP_XOR) || (i_opcode == OP_RED) ||
                (i_opcode == OP_SW);
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control registers,
// RAW hazard stalls, flush/freeze and halt sequencing. Macro PIPE_CTRL_FWD_EN.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned ALUOP_W    = 3,
  parameter bit          R0_IS_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            opcode_id,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  flush_id,
  input  logic                  stall_ext,
  output logic                  stall_if_id,
  output logic                  pc_hold,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_branch_src,
  output logic                  ex_pcs,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  halted
`ifdef PIPE_CTRL_FWD_EN
  ,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
`endif
);

  ctrl_t                 w_dec_ctrl;
  logic                  w_rs_used;
  logic                  w_rt_used;
  logic                  w_hz;
  logic                  w_insert;

  ctrl_t                 r_idex_ctrl;
  logic [REG_ADDR_W-1:0] r_idex_rs;
  logic [REG_ADDR_W-1:0] r_idex_rt;
  logic [REG_ADDR_W-1:0] r_idex_rd;
  logic                  r_exmem_mem_read;
  logic                  r_exmem_mem_write;
  logic                  r_exmem_mem_to_reg;
  logic                  r_exmem_reg_write;
  logic                  r_exmem_halt;
  logic [REG_ADDR_W-1:0] r_exmem_rd;
  logic                  r_memwb_reg_write;
  logic                  r_memwb_mem_to_reg;
  logic [REG_ADDR_W-1:0] r_memwb_rd;
  logic                  r_pc_hold;
  logic                  r_halted;
`ifdef PIPE_CTRL_FWD_EN
  logic                  r_idex_rs_used;
  logic                  r_idex_rt_used;
`endif

  ctrl_decode u_ctrl_decode (
    .i_opcode  (opcode_id),
    .o_ctrl    (w_dec_ctrl),
    .o_rs_used (w_rs_used),
    .o_rt_used (w_rt_used)
  );

  // A register 0 source never depends on an older writer when it is hardwired.
  function automatic logic f_match(input logic                  used,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] dst,
                                   input logic                  wr);
    return used && wr && (src == dst) && !(R0_IS_ZERO && (src == '0));
  endfunction

  always_comb begin
`ifdef PIPE_CTRL_FWD_EN
    w_hz = r_idex_ctrl.mem_read &&
           (f_match(w_rs_used, rs_id, r_idex_rd, r_idex_ctrl.reg_write) ||
            f_match(w_rt_used, rt_id, r_idex_rd, r_idex_ctrl.reg_write));
`else
    w_hz = f_match(w_rs_used, rs_id, r_idex_rd,  r_idex_ctrl.reg_write) ||
           f_match(w_rt_used, rt_id, r_idex_rd,  r_idex_ctrl.reg_write) ||
           f_match(w_rs_used, rs_id, r_exmem_rd, r_exmem_reg_write)     ||
           f_match(w_rt_used, rt_id, r_exmem_rd, r_exmem_reg_write);
`endif
    w_insert    = !flush_id && !w_hz;
    stall_if_id = stall_ext || (!flush_id && w_hz);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex_ctrl        <= CTRL_NOP;
      r_idex_rs          <= '0;
      r_idex_rt          <= '0;
      r_idex_rd          <= '0;
      r_exmem_mem_read   <= 1'b0;
      r_exmem_mem_write  <= 1'b0;
      r_exmem_mem_to_reg <= 1'b0;
      r_exmem_reg_write  <= 1'b0;
      r_exmem_halt       <= 1'b0;
      r_exmem_rd         <= '0;
      r_memwb_reg_write  <= 1'b0;
      r_memwb_mem_to_reg <= 1'b0;
      r_memwb_rd         <= '0;
      r_pc_hold          <= 1'b0;
      r_halted           <= 1'b0;
`ifdef PIPE_CTRL_FWD_EN
      r_idex_rs_used     <= 1'b0;
      r_idex_rt_used     <= 1'b0;
`endif
    end else if (!stall_ext) begin
      r_exmem_mem_read   <= r_idex_ctrl.mem_read;
      r_exmem_mem_write  <= r_idex_ctrl.mem_write;
      r_exmem_mem_to_reg <= r_idex_ctrl.mem_to_reg;
      r_exmem_reg_write  <= r_idex_ctrl.reg_write;
      r_exmem_halt       <= r_idex_ctrl.halt;
      r_exmem_rd         <= r_idex_rd;
      r_memwb_reg_write  <= r_exmem_reg_write;
      r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
      r_memwb_rd         <= r_exmem_rd;
      if (r_exmem_halt) r_halted <= 1'b1;

      // Flush and hazard both inject a bubble; only a real insert may set pc_hold.
      if (w_insert) begin
        r_idex_ctrl <= w_dec_ctrl;
        r_idex_rs   <= rs_id;
        r_idex_rt   <= rt_id;
        r_idex_rd   <= rd_id;
        if (w_dec_ctrl.halt) r_pc_hold <= 1'b1;
      end else begin
        r_idex_ctrl <= CTRL_NOP;
        r_idex_rs   <= '0;
        r_idex_rt   <= '0;
        r_idex_rd   <= '0;
      end
`ifdef PIPE_CTRL_FWD_EN
      r_idex_rs_used <= w_insert && w_rs_used;
      r_idex_rt_used <= w_insert && w_rt_used;
`endif
    end
  end

`ifdef PIPE_CTRL_FWD_EN
  always_comb begin
    fwd_a_sel = FWD_NONE;
    fwd_b_sel = FWD_NONE;
    if (f_match(r_idex_rs_used, r_idex_rs, r_exmem_rd, r_exmem_reg_write))
      fwd_a_sel = FWD_EXMEM;
    else if (f_match(r_idex_rs_used, r_idex_rs, r_memwb_rd, r_memwb_reg_write))
      fwd_a_sel = FWD_MEMWB;
    if (f_match(r_idex_rt_used, r_idex_rt, r_exmem_rd, r_exmem_reg_write))
      fwd_b_sel = FWD_EXMEM;
    else if (f_match(r_idex_rt_used, r_idex_rt, r_memwb_rd, r_memwb_reg_write))
      fwd_b_sel = FWD_MEMWB;
  end
`endif

  always_comb begin
    ex_alu_op     = ALUOP_W'(r_idex_ctrl.alu_op);
    ex_alu_src    = r_idex_ctrl.alu_src;
    ex_branch     = r_idex_ctrl.branch;
    ex_branch_src = r_idex_ctrl.branch_src;
    ex_pcs        = r_idex_ctrl.pcs;
    ex_rs         = r_idex_rs;
    ex_rt         = r_idex_rt;
    mem_read      = r_exmem_mem_read;
    mem_write     = r_exmem_mem_write;
    wb_reg_write  = r_memwb_reg_write;
    wb_mem_to_reg = r_memwb_mem_to_reg;
    wb_rd         = r_memwb_rd;
    pc_hold       = r_pc_hold;
    halted        = r_halted;
  end

endmodule
